// File: rtl/tl_pkg.sv
// TileLink payload types and shared constants for the channel buffer.
package tl_pkg;

    localparam int unsigned TL_BUF_PERF_W = 16;
    localparam int unsigned TL_NUM_CH     = 5;

    localparam int unsigned TL_CH_A = 0;
    localparam int unsigned TL_CH_B = 1;
    localparam int unsigned TL_CH_C = 2;
    localparam int unsigned TL_CH_D = 3;
    localparam int unsigned TL_CH_E = 4;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [3:0]  source;
        logic [31:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
    } tl_a_chan_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [1:0]  size;
        logic [3:0]  source;
        logic [31:0] address;
    } tl_b_chan_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [3:0]  source;
        logic [31:0] address;
        logic [31:0] data;
    } tl_c_chan_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [1:0]  size;
        logic [3:0]  source;
        logic [3:0]  sink;
        logic        denied;
        logic [31:0] data;
    } tl_d_chan_t;

    typedef struct packed {
        logic [3:0] sink;
    } tl_e_chan_t;

endpackage

// File: rtl/TL_BUS.sv
// Five-channel TileLink bus. Modports are named after the agent on the far side:
// Master faces a master (A/C/E arrive), Slave faces a slave (A/C/E leave).
interface TL_BUS;
    import tl_pkg::*;

    logic       a_valid;
    logic       a_ready;
    tl_a_chan_t a_bits;
    logic       b_valid;
    logic       b_ready;
    tl_b_chan_t b_bits;
    logic       c_valid;
    logic       c_ready;
    tl_c_chan_t c_bits;
    logic       d_valid;
    logic       d_ready;
    tl_d_chan_t d_bits;
    logic       e_valid;
    logic       e_ready;
    tl_e_chan_t e_bits;

    modport Master (
        input  a_valid, a_bits, output a_ready,
        output b_valid, b_bits, input  b_ready,
        input  c_valid, c_bits, output c_ready,
        output d_valid, d_bits, input  d_ready,
        input  e_valid, e_bits, output e_ready
    );

    modport Slave (
        output a_valid, a_bits, input  a_ready,
        input  b_valid, b_bits, output b_ready,
        output c_valid, c_bits, input  c_ready,
        input  d_valid, d_bits, output d_ready,
        output e_valid, e_bits, input  e_ready
    );

endinterface

// File: rtl/tl_chan_fifo.sv
// Single-channel valid/ready circular FIFO (DEPTH >= 1), optional fall-through when empty.
module tl_chan_fifo #(
    parameter type         T            = logic,
    parameter int unsigned DEPTH        = 2,
    parameter bit          FALL_THROUGH = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_valid_i,
    output logic src_ready_o,
    input  T     src_data_i,
    output logic dst_valid_o,
    input  logic dst_ready_i,
    output T     dst_data_o,
    output logic empty_o,
    output logic full_o
);

    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bypass;
    logic          push;
    logic          pop;

    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == CNT_FULL);
    // Ready depends only on stored count, so a full queue never accepts in the pop cycle.
    assign src_ready_o = !full_o;

    assign bypass      = FALL_THROUGH && empty_o;
    assign dst_valid_o = bypass ? src_valid_i : !empty_o;
    assign dst_data_o  = bypass ? src_data_i : mem_q[rptr_q];

    assign push = src_valid_i && !full_o && !(bypass && dst_ready_i);
    assign pop  = !empty_o && dst_ready_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= src_data_i;
        end
    end

endmodule

// File: rtl/tl_chan_fifo_buffer.sv
// Per-channel TileLink buffer between two TL_BUS ports; depth 0 channels are plain wires.
// Optional full-stall counters are built when TL_BUFFER_PERF_EN is defined.
module tl_chan_fifo_buffer
    import tl_pkg::*;
#(
    parameter int unsigned A_DEPTH      = 2,
    parameter int unsigned B_DEPTH      = 2,
    parameter int unsigned C_DEPTH      = 2,
    parameter int unsigned D_DEPTH      = 2,
    parameter int unsigned E_DEPTH      = 2,
    parameter bit          FALL_THROUGH = 1'b0
) (
    input  logic   clk_i,
    input  logic   rst_i,
    TL_BUS.Master  in,
    TL_BUS.Slave   out,
    output logic   idle_o
`ifdef TL_BUFFER_PERF_EN
   ,input  logic   perf_clr_i,
    output logic [TL_NUM_CH-1:0][TL_BUF_PERF_W-1:0] perf_full_cnt_o
`endif
);

    logic [TL_NUM_CH-1:0] empty;
    logic [TL_NUM_CH-1:0] full;

    assign idle_o = &empty;

    if (A_DEPTH == 0) begin : g_a_wire
        assign out.a_valid    = in.a_valid;
        assign out.a_bits     = in.a_bits;
        assign in.a_ready     = out.a_ready;
        assign empty[TL_CH_A] = 1'b1;
        assign full[TL_CH_A]  = 1'b0;
    end else begin : g_a_fifo
        tl_chan_fifo #(.T(tl_a_chan_t), .DEPTH(A_DEPTH), .FALL_THROUGH(FALL_THROUGH)) u_fifo (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .src_valid_i (in.a_valid),
            .src_ready_o (in.a_ready),
            .src_data_i  (in.a_bits),
            .dst_valid_o (out.a_valid),
            .dst_ready_i (out.a_ready),
            .dst_data_o  (out.a_bits),
            .empty_o     (empty[TL_CH_A]),
            .full_o      (full[TL_CH_A])
        );
    end

    if (B_DEPTH == 0) begin : g_b_wire
        assign in.b_valid     = out.b_valid;
        assign in.b_bits      = out.b_bits;
        assign out.b_ready    = in.b_ready;
        assign empty[TL_CH_B] = 1'b1;
        assign full[TL_CH_B]  = 1'b0;
    end else begin : g_b_fifo
        tl_chan_fifo #(.T(tl_b_chan_t), .DEPTH(B_DEPTH), .FALL_THROUGH(FALL_THROUGH)) u_fifo (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .src_valid_i (out.b_valid),
            .src_ready_o (out.b_ready),
            .src_data_i  (out.b_bits),
            .dst_valid_o (in.b_valid),
            .dst_ready_i (in.b_ready),
            .dst_data_o  (in.b_bits),
            .empty_o     (empty[TL_CH_B]),
            .full_o      (full[TL_CH_B])
        );
    end

    if (C_DEPTH == 0) begin : g_c_wire
        assign out.c_valid    = in.c_valid;
        assign out.c_bits     = in.c_bits;
        assign in.c_ready     = out.c_ready;
        assign empty[TL_CH_C] = 1'b1;
        assign full[TL_CH_C]  = 1'b0;
    end else begin : g_c_fifo
        tl_chan_fifo #(.T(tl_c_chan_t), .DEPTH(C_DEPTH), .FALL_THROUGH(FALL_THROUGH)) u_fifo (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .src_valid_i (in.c_valid),
            .src_ready_o (in.c_ready),
            .src_data_i  (in.c_bits),
            .dst_valid_o (out.c_valid),
            .dst_ready_i (out.c_ready),
            .dst_data_o  (out.c_bits),
            .empty_o     (empty[TL_CH_C]),
            .full_o      (full[TL_CH_C])
        );
    end

    if (D_DEPTH == 0) begin : g_d_wire
        assign in.d_valid     = out.d_valid;
        assign in.d_bits      = out.d_bits;
        assign out.d_ready    = in.d_ready;
        assign empty[TL_CH_D] = 1'b1;
        assign full[TL_CH_D]  = 1'b0;
    end else begin : g_d_fifo
        tl_chan_fifo #(.T(tl_d_chan_t), .DEPTH(D_DEPTH), .FALL_THROUGH(FALL_THROUGH)) u_fifo (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .src_valid_i (out.d_valid),
            .src_ready_o (out.d_ready),
            .src_data_i  (out.d_bits),
            .dst_valid_o (in.d_valid),
            .dst_ready_i (in.d_ready),
            .dst_data_o  (in.d_bits),
            .empty_o     (empty[TL_CH_D]),
            .full_o      (full[TL_CH_D])
        );
    end

    if (E_DEPTH == 0) begin : g_e_wire
        assign out.e_valid    = in.e_valid;
        assign out.e_bits     = in.e_bits;
        assign in.e_ready     = out.e_ready;
        assign empty[TL_CH_E] = 1'b1;
        assign full[TL_CH_E]  = 1'b0;
    end else begin : g_e_fifo
        tl_chan_fifo #(.T(tl_e_chan_t), .DEPTH(E_DEPTH), .FALL_THROUGH(FALL_THROUGH)) u_fifo (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .src_valid_i (in.e_valid),
            .src_ready_o (in.e_ready),
            .src_data_i  (in.e_bits),
            .dst_valid_o (out.e_valid),
            .dst_ready_i (out.e_ready),
            .dst_data_o  (out.e_bits),
            .empty_o     (empty[TL_CH_E]),
            .full_o      (full[TL_CH_E])
        );
    end

`ifdef TL_BUFFER_PERF_EN
    localparam logic [TL_NUM_CH-1:0] HAS_Q = {E_DEPTH != 0, D_DEPTH != 0, C_DEPTH != 0,
                                              B_DEPTH != 0, A_DEPTH != 0};

    logic [TL_NUM_CH-1:0]                     src_valid;
    logic [TL_NUM_CH-1:0][TL_BUF_PERF_W-1:0] perf_q, perf_d;

    assign src_valid = {in.e_valid, out.d_valid, in.c_valid, out.b_valid, in.a_valid};

    // Stall = queue full while its source still offers a beat; saturating, clear wins.
    always_comb begin
        perf_d = perf_q;
        for (int unsigned ch = 0; ch < TL_NUM_CH; ch++) begin
            if (!HAS_Q[ch] || perf_clr_i) begin
                perf_d[ch] = '0;
            end else if (full[ch] && src_valid[ch] && (perf_q[ch] != '1)) begin
                perf_d[ch] = perf_q[ch] + TL_BUF_PERF_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_full_cnt_o = perf_q;
`else
    logic unused_full;
    assign unused_full = ^full;
`endif

endmodule

// File: tb/tb_tl_chan_fifo_buffer.sv
// Directed bench: dut0 (A=3,B=2,C=2,D=1,E=3, registered) and dut1 (all 2, B wire, fall-through).
module tb_tl_chan_fifo_buffer;
    import tl_pkg::*;

    logic clk;
    logic rst_i;
    logic idle0, idle1;
    int   errors = 0;
    int   checks = 0;

    TL_BUS in0 ();
    TL_BUS out0 ();
    TL_BUS in1 ();
    TL_BUS out1 ();

`ifdef TL_BUFFER_PERF_EN
    logic perf_clr;
    logic [TL_NUM_CH-1:0][TL_BUF_PERF_W-1:0] perf0, perf1;
`endif

    tl_chan_fifo_buffer #(
        .A_DEPTH(3), .B_DEPTH(2), .C_DEPTH(2), .D_DEPTH(1), .E_DEPTH(3), .FALL_THROUGH(1'b0)
    ) dut0 (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .in     (in0.Master),
        .out    (out0.Slave),
        .idle_o (idle0)
`ifdef TL_BUFFER_PERF_EN
       ,.perf_clr_i      (perf_clr),
        .perf_full_cnt_o (perf0)
`endif
    );

    tl_chan_fifo_buffer #(
        .A_DEPTH(2), .B_DEPTH(0), .C_DEPTH(2), .D_DEPTH(2), .E_DEPTH(2), .FALL_THROUGH(1'b1)
    ) dut1 (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .in     (in1.Master),
        .out    (out1.Slave),
        .idle_o (idle1)
`ifdef TL_BUFFER_PERF_EN
       ,.perf_clr_i      (perf_clr),
        .perf_full_cnt_o (perf1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int  sent, rcvd;
    logic push, pop;

    initial begin
        rst_i = 1'b0;
`ifdef TL_BUFFER_PERF_EN
        perf_clr = 1'b0;
`endif
        in0.a_valid = 0; in0.a_bits = '0; in0.c_valid = 0; in0.c_bits = '0;
        in0.e_valid = 0; in0.e_bits = '0; in0.b_ready = 0; in0.d_ready = 0;
        out0.b_valid = 0; out0.b_bits = '0; out0.d_valid = 0; out0.d_bits = '0;
        out0.a_ready = 0; out0.c_ready = 0; out0.e_ready = 0;
        in1.a_valid = 0; in1.a_bits = '0; in1.c_valid = 0; in1.c_bits = '0;
        in1.e_valid = 0; in1.e_bits = '0; in1.b_ready = 0; in1.d_ready = 0;
        out1.b_valid = 0; out1.b_bits = '0; out1.d_valid = 0; out1.d_bits = '0;
        out1.a_ready = 0; out1.c_ready = 0; out1.e_ready = 0;

        // Reset with A offered: nothing enters.
        in0.a_valid = 1; in0.a_bits.data = 32'hA5;
        #1;
        chk("rst_a_valid", out0.a_valid, 0);
        chk("rst_a_ready", in0.a_ready, 1);
        chk("rst_d_ready", out0.d_ready, 1);
        chk("rst_idle0", idle0, 1);
        chk("rst_idle1", idle1, 1);
        tick(); tick();
        chk("rst_hold_a_valid", out0.a_valid, 0);
        rst_i = 1'b1;
        #1;
        chk("lat_pre_edge", out0.a_valid, 0);
        tick();
        chk("lat_a_valid", out0.a_valid, 1);
        chk("lat_a_data", out0.a_bits.data, 32'hA5);
        chk("lat_idle", idle0, 0);
        in0.a_valid = 0; out0.a_ready = 1;
        tick();
        chk("pop_a_valid", out0.a_valid, 0);
        chk("pop_idle", idle0, 1);
        out0.a_ready = 0;

        // Back-pressure on A (depth 3).
        for (int i = 1; i <= 4; i++) begin
            in0.a_valid = 1; in0.a_bits.data = 32'(i);
            #1;
            chk("bp_ready", in0.a_ready, (i <= 3) ? 1 : 0);
            tick();
        end
        out0.a_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_out_valid", out0.a_valid, 1);
            chk("bp_out_data", out0.a_bits.data, k + 1);
            if (k < 2) chk("bp_ready_rel", in0.a_ready, (k == 1) ? 1 : 0);
            tick();
            if (k == 1) in0.a_valid = 0;
        end
        #1;
        chk("bp_drained", out0.a_valid, 0);
        chk("bp_idle", idle0, 1);
        out0.a_ready = 0;
`ifdef TL_BUFFER_PERF_EN
        chk("perf_a_stall", perf0[TL_CH_A], 2);
`endif

        // D depth 1: full with simultaneous pop.
        out0.d_valid = 1; out0.d_bits.data = 32'h11;
        #1;
        chk("d1_ready_empty", out0.d_ready, 1);
        tick();
        out0.d_bits.data = 32'h22; in0.d_ready = 1;
        #1;
        chk("d1_valid", in0.d_valid, 1);
        chk("d1_data", in0.d_bits.data, 32'h11);
        chk("d1_ready_full", out0.d_ready, 0);
        tick();
        chk("d1_gap_valid", in0.d_valid, 0);
        chk("d1_ready_after", out0.d_ready, 1);
        tick();
        out0.d_valid = 0;
        #1;
        chk("d1_second_valid", in0.d_valid, 1);
        chk("d1_second_data", in0.d_bits.data, 32'h22);
        tick();
        chk("d1_empty", in0.d_valid, 0);
        chk("d1_idle", idle0, 1);
        in0.d_ready = 0;

        // Fall-through on C, sink ready: beat passes unstored.
        out1.c_ready = 1; in1.c_valid = 1; in1.c_bits.data = 32'h3C;
        #1;
        chk("ft_valid", out1.c_valid, 1);
        chk("ft_data", out1.c_bits.data, 32'h3C);
        chk("ft_ready", in1.c_ready, 1);
        chk("ft_idle", idle1, 1);
        tick();
        chk("ft_idle_after", idle1, 1);
        in1.c_valid = 0;
        #1;
        chk("ft_no_residue", out1.c_valid, 0);
        // Fall-through, sink stalled: beat stored.
        out1.c_ready = 0; in1.c_valid = 1; in1.c_bits.data = 32'h5A;
        #1;
        chk("ft_stall_valid", out1.c_valid, 1);
        tick();
        in1.c_valid = 0; in1.c_bits.data = 32'h0;
        #1;
        chk("ft_stored_valid", out1.c_valid, 1);
        chk("ft_stored_data", out1.c_bits.data, 32'h5A);
        chk("ft_stored_idle", idle1, 0);
        out1.c_ready = 1;
        tick();
        chk("ft_drain_idle", idle1, 1);
        out1.c_ready = 0;

        // Depth-0 B on dut1 is a wire.
        out1.b_valid = 1; out1.b_bits.address = 32'h1234;
        #1;
        chk("wire_b_valid", in1.b_valid, 1);
        chk("wire_b_addr", in1.b_bits.address, 32'h1234);
        chk("wire_b_ready_lo", out1.b_ready, 0);
        in1.b_ready = 1;
        #1;
        chk("wire_b_ready_hi", out1.b_ready, 1);
        chk("wire_idle", idle1, 1);
        out1.b_valid = 0; in1.b_ready = 0;

        // E depth 3: ten beats, random sink ready, order preserved across wraps.
        sent = 0; rcvd = 0;
        for (int cyc = 0; cyc < 300 && rcvd < 10; cyc++) begin
            in0.e_valid = (sent < 10);
            in0.e_bits.sink = 4'(sent);
            out0.e_ready = 1'($urandom_range(0, 1));
            #1;
            push = in0.e_valid && in0.e_ready;
            pop  = out0.e_valid && out0.e_ready;
            if (pop) begin
                chk("wrap_order", out0.e_bits.sink, rcvd);
                rcvd++;
            end
            tick();
            if (push) sent++;
        end
        chk("wrap_count", rcvd, 10);
        in0.e_valid = 0; out0.e_ready = 0;
        #1;
        chk("wrap_idle", idle0, 1);

`ifdef TL_BUFFER_PERF_EN
        // B depth 2: two fills, then five stalled cycles.
        in0.b_ready = 0; out0.b_valid = 1;
        tick(); tick();
        for (int i = 0; i < 5; i++) tick();
        chk("perf_b_five", perf0[TL_CH_B], 5);
        chk("perf_b_full", out0.b_ready, 0);
        chk("perf1_b_wire", perf1[TL_CH_B], 0);
        out0.b_valid = 0; perf_clr = 1;
        tick();
        chk("perf_b_clr", perf0[TL_CH_B], 0);
        perf_clr = 0;
        in0.b_ready = 1;
        tick(); tick();
        in0.b_ready = 0;
        #1;
        chk("perf_b_idle", idle0, 1);
`endif

        // Reset mid-transfer drops queued beats at once.
        in0.c_valid = 1; in0.c_bits.data = 32'h77;
        tick();
        in0.c_valid = 0;
        #1;
        chk("mid_c_valid", out0.c_valid, 1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_c_valid", out0.c_valid, 0);
        chk("mid_rst_idle", idle0, 1);
        tick();
        rst_i = 1'b1;
        #1;
        chk("mid_post_c_valid", out0.c_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
